llc_mem_read_arbiter: RTL and testbench
=======================================

# llc_mem_read_arbiter

Shares the single AXI read master port (AR + R channels) between two read requesters: requester 0 is the LLC line-refill path and requester 1 is a secondary memory client such as a page-table walker or prefetcher. Requests are granted round-robin, one complete burst at a time. The grant is held from address acceptance until the R beat carrying `rlast` completes, so R beats never interleave between requesters. The block sits between the LLC and the system AXI interconnect.

## Interface
- `ADDR_WIDTH`, 64, address width.
- `DATA_WIDTH`, 64, R beat width.
- `BEATS_PER_BURST`, 8, expected beats per line refill (512-bit line / 64-bit beat).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s0_axi_araddr` / `s1_axi_araddr`  in  ADDR_WIDTH  requester read address.
- `s0_axi_arvalid` / `s1_axi_arvalid`  in  1  requester address valid.
- `s0_axi_arready` / `s1_axi_arready`  out  1  requester address accepted.
- `s0_axi_rdata` / `s1_axi_rdata`  out  DATA_WIDTH  beat data, broadcast copy of `m_axi_rdata`.
- `s0_axi_rvalid` / `s1_axi_rvalid`  out  1  beat valid; asserted only toward the granted requester.
- `s0_axi_rlast` / `s1_axi_rlast`  out  1  last beat; asserted only toward the granted requester.
- `s0_axi_rready` / `s1_axi_rready`  in  1  requester beat ready.
- `m_axi_araddr`  out  ADDR_WIDTH  latched granted address.
- `m_axi_arvalid`  out  1  address valid to memory.
- `m_axi_arready`  in  1  memory address accepted.
- `m_axi_rdata`  in  DATA_WIDTH  memory beat.
- `m_axi_rvalid`, `m_axi_rlast`  in  1  memory beat valid / last.
- `m_axi_rready`  out  1  equal to the granted requester's `rready` while in DATA, else 0.
- `grant_id`  out  1  requester currently owning the port.
- `busy`  out  1  high in ADDR and DATA.
- `burst_err`  out  1  sticky burst-length error (see Configuration).

## Operation
- State machine states: IDLE, ADDR, DATA.
- IDLE, no arvalid: remain in IDLE.
- IDLE, one arvalid: that requester wins.
- IDLE, both arvalid: the winner is the requester that is not `last_grant`. `last_grant` resets to 1, so requester 0 wins the first tie.
- IDLE accept: `sX_axi_arready` is asserted combinationally for the winner only, for exactly that one cycle. On that edge the block latches `araddr` into the `m_axi_araddr` register, sets `grant_id` = X and moves to ADDR.
- ADDR: `m_axi_arvalid` = 1 and `m_axi_araddr` is held stable. When `m_axi_arready` = 1, move to DATA.
- DATA, routing: `sX_axi_rvalid` = `m_axi_rvalid` and `sX_axi_rlast` = `m_axi_rlast` for X = `grant_id`; the other requester sees 0. `m_axi_rready` = `sX_axi_rready` for X = `grant_id`.
- DATA, beat count: each handshake (rvalid & rready) increments a `$clog2(BEATS_PER_BURST)+1`-bit beat counter. The counter clears when entering ADDR.
- DATA, end of burst: a handshake with `m_axi_rlast` = 1 sets `last_grant` = `grant_id` and moves to IDLE.
- A requester's `arvalid` that drops while it is not granted is simply ignored; no request is queued internally.
- Both `sX_axi_arready` outputs are 0 outside IDLE.

## Timing
- Reset values: state = IDLE; `last_grant` = 1; `grant_id` = 0; beat counter = 0; `burst_err` = 0; `m_axi_araddr` = 0.
- Reset values (cont.): `m_axi_arvalid`, `m_axi_rready`, `busy` = 0; all `sX_arready`, `sX_rvalid` and `sX_rlast` = 0.
- Latency: `sX_arvalid` sampled in cycle N (block in IDLE) gives `m_axi_arvalid` = 1 in cycle N+1.
- R path is combinational pass-through: 0 cycles from `m_axi_rvalid` to the granted `rvalid`.
- A new burst can be accepted the cycle after the `rlast` handshake. The minimum per-burst overhead is therefore 2 cycles (IDLE accept + ADDR) plus the memory latency.
- Backpressure: if the granted requester holds `rready` = 0, `m_axi_rready` = 0 and the beat stalls. The grant is not released.
- Reset mid-burst: return to IDLE next cycle with all outputs at reset values. Any memory beats still in flight are not consumed (`m_axi_rready` = 0). Downstream reset must clear the interconnect.

## Configuration
- `LLC_RD_ARB_BURST_CHECK_EN` defined: `burst_err` is set, and held until reset, when either of these occurs:
  - an `rlast` handshake completes with the beat count ≠ `BEATS_PER_BURST`;
  - a beat handshake occurs with the count already at `BEATS_PER_BURST`.
- Routing and grant release are unaffected by the check; release still occurs on `rlast`.
- Undefined: the beat-count comparison logic is not compiled and `burst_err` is tied to 0.

## Test plan
- Single request: s0 arvalid with `araddr` = 0x1000, memory arready after 3 cycles, 8 beats 0xA0..0xA7 with rlast on the 8th → s0 receives all 8 beats in order; `s1_rvalid` stays 0; block back in IDLE on the cycle after rlast.
- Simultaneous after reset: s0 @0x2000 and s1 @0x3000 both valid → s0 granted first (`m_axi_araddr` = 0x2000); s1 granted in the IDLE cycle following s0's rlast (0x3000).
- Round-robin fairness: both requesters held valid for 4 bursts → grant sequence 0, 1, 0, 1.
- R backpressure: s1 granted, s1 rready low for beats 3–5 → `m_axi_rready` low for those cycles; no beat lost or duplicated; grant is held throughout.
- Reset mid-burst: assert reset after beat 4 → next cycle state is IDLE, `busy` = 0, `m_axi_rready` = 0, all outputs at reset values.
- Bad burst length (with `LLC_RD_ARB_BURST_CHECK_EN`): rlast on beat 6 → `burst_err` = 1, held until reset; grant still released.
- Bad burst length (without the macro): same stimulus → `burst_err` stays 0.

Source files
------------

// File: rtl/llc_mem_read_arbiter.sv
// llc_mem_read_arbiter: round-robin, burst-granular sharing of one AXI read port between two requesters.
// Optional burst-length check compiled in with LLC_RD_ARB_BURST_CHECK_EN.
module llc_mem_read_arbiter #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int BEATS_PER_BURST = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic                  s0_axi_rvalid,
    output logic                  s0_axi_rlast,
    input  logic                  s0_axi_rready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic                  s1_axi_rvalid,
    output logic                  s1_axi_rlast,
    input  logic                  s1_axi_rready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rvalid,
    input  logic                  m_axi_rlast,
    output logic                  m_axi_rready,
    output logic                  grant_id,
    output logic                  busy,
    output logic                  burst_err
);
    localparam int CW = $clog2(BEATS_PER_BURST) + 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic                  win, accept, in_data, hs;

    // On a tie the requester that did not own the previous burst wins
    assign win     = (s0_axi_arvalid & s1_axi_arvalid) ? ~last_grant_q : ~s0_axi_arvalid;
    assign accept  = (state_q == IDLE) & (s0_axi_arvalid | s1_axi_arvalid);
    assign in_data = (state_q == DATA);
    assign hs      = in_data & m_axi_rvalid & m_axi_rready;
    assign cnt_inc = cnt_q + 1'b1;

    assign s0_axi_arready = accept & ~win;
    assign s1_axi_arready = accept & win;
    assign m_axi_arvalid  = (state_q == ADDR);
    assign m_axi_araddr   = addr_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != IDLE);
    assign m_axi_rready   = in_data & (grant_q ? s1_axi_rready : s0_axi_rready);
    assign s0_axi_rdata   = m_axi_rdata;
    assign s1_axi_rdata   = m_axi_rdata;
    assign s0_axi_rvalid  = in_data & ~grant_q & m_axi_rvalid;
    assign s1_axi_rvalid  = in_data & grant_q & m_axi_rvalid;
    assign s0_axi_rlast   = in_data & ~grant_q & m_axi_rlast;
    assign s1_axi_rlast   = in_data & grant_q & m_axi_rlast;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = ADDR;
                grant_d = win;
                addr_d  = win ? s1_axi_araddr : s0_axi_araddr;
                cnt_d   = '0;
            end
            ADDR: if (m_axi_arready) state_d = DATA;
            DATA: if (hs) begin
                cnt_d = cnt_inc;
                if (m_axi_rlast) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef LLC_RD_ARB_BURST_CHECK_EN
    localparam logic [CW-1:0] BEATS = CW'(BEATS_PER_BURST);
    logic err_q;
    // Flags a short/long rlast or any beat beyond the expected burst length
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_q | (hs & ((m_axi_rlast & (cnt_inc != BEATS)) | (cnt_q == BEATS)));
    end
    assign burst_err = err_q;
`else
    assign burst_err = 1'b0;
`endif

endmodule

// File: tb/tb_llc_mem_read_arbiter.sv
// tb_llc_mem_read_arbiter: directed stimulus, per-cycle reference model compare plus literal checks.
module tb_llc_mem_read_arbiter;
    logic        clk = 0, reset = 1;
    logic [63:0] s0_araddr = 0, s1_araddr = 0, m_rdata = 0;
    logic        s0v = 0, s1v = 0, s0_rready = 1, s1_rready = 1;
    logic        m_arready = 0, m_rvalid = 0, m_rlast = 0;
    logic        s0_axi_arready, s1_axi_arready, s0_axi_rvalid, s1_axi_rvalid, s0_axi_rlast, s1_axi_rlast;
    logic [63:0] s0_axi_rdata, s1_axi_rdata, m_axi_araddr;
    logic        m_axi_arvalid, m_axi_rready, grant_id, busy, burst_err;

`ifdef LLC_RD_ARB_BURST_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    llc_mem_read_arbiter dut (
        .clk(clk), .reset(reset),
        .s0_axi_araddr(s0_araddr), .s0_axi_arvalid(s0v), .s0_axi_arready(s0_axi_arready),
        .s0_axi_rdata(s0_axi_rdata), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rlast(s0_axi_rlast),
        .s0_axi_rready(s0_rready),
        .s1_axi_araddr(s1_araddr), .s1_axi_arvalid(s1v), .s1_axi_arready(s1_axi_arready),
        .s1_axi_rdata(s1_axi_rdata), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rlast(s1_axi_rlast),
        .s1_axi_rready(s1_rready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rvalid(m_rvalid), .m_axi_rlast(m_rlast), .m_axi_rready(m_axi_rready),
        .grant_id(grant_id), .busy(busy), .burst_err(burst_err)
    );

    int n_cmp = 0, n_bad = 0;
    int left0 = 0, left1 = 0;
    logic [63:0] got0[$], got1[$];
    int glog[$];

    // Reference model: who owns the port, whether its address is still pending, and burst bookkeeping
    int          m_owner = -1, m_last = 1, m_gid = 0, m_cnt = 0;
    bit          m_aph = 0, m_err = 0;
    logic [63:0] m_addr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : cmp
        int win;
        bit fr, dt, rr;
        fr  = m_owner < 0;
        win = (s0v && s1v) ? 1 - m_last : s0v ? 0 : s1v ? 1 : -1;
        dt  = !fr && !m_aph;
        rr  = m_gid ? s1_rready : s0_rready;
        chk("s0_arready", s0_axi_arready, fr && win == 0);
        chk("s1_arready", s1_axi_arready, fr && win == 1);
        chk("m_arvalid", m_axi_arvalid, !fr && m_aph);
        chk("m_araddr", m_axi_araddr, m_addr);
        chk("grant_id", grant_id, m_gid);
        chk("busy", busy, !fr);
        chk("s0_rvalid", s0_axi_rvalid, dt && m_gid == 0 && m_rvalid);
        chk("s1_rvalid", s1_axi_rvalid, dt && m_gid == 1 && m_rvalid);
        chk("s0_rlast", s0_axi_rlast, dt && m_gid == 0 && m_rlast);
        chk("s1_rlast", s1_axi_rlast, dt && m_gid == 1 && m_rlast);
        chk("m_rready", m_axi_rready, dt && rr);
        chk("s0_rdata", s0_axi_rdata, m_rdata);
        chk("s1_rdata", s1_axi_rdata, m_rdata);
        chk("burst_err", burst_err, CHK ? m_err : 1'b0);
        if (!reset) begin
            if (s0_axi_rvalid && s0_rready) got0.push_back(s0_axi_rdata);
            if (s1_axi_rvalid && s1_rready) got1.push_back(s1_axi_rdata);
            if (s0_axi_arready) glog.push_back(0);
            if (s1_axi_arready) glog.push_back(1);
        end
        if (reset) begin
            m_owner = -1; m_aph = 0; m_last = 1; m_gid = 0; m_addr = 0; m_cnt = 0; m_err = 0;
        end else if (fr) begin
            if (win >= 0) begin
                m_owner = win; m_gid = win; m_aph = 1; m_cnt = 0;
                m_addr  = win == 1 ? s1_araddr : s0_araddr;
            end
        end else if (m_aph) begin
            if (m_arready) m_aph = 0;
        end else if (m_rvalid && rr) begin
            if ((m_rlast && m_cnt + 1 != 8) || m_cnt == 8) m_err = 1;
            m_cnt++;
            if (m_rlast) begin
                m_last  = m_gid;
                m_owner = -1;
            end
        end
    end

    // One clock; requests are withdrawn once their remaining count is used up
    task automatic cyc();
        bit a0, a1;
        @(negedge clk);
        a0 = s0_axi_arready;
        a1 = s1_axi_arready;
        @(posedge clk);
        #1;
        if (a0) begin left0--; s0v = left0 > 0; end
        if (a1) begin left1--; s1v = left1 > 0; end
    endtask

    task automatic serve(input int nb, input logic [63:0] db, input int ard, input int slo, input int shi,
                         input int gid, input logic [63:0] ea, input int rst_after);
        int t;
        t = 0;
        while (!m_axi_arvalid && t < 20) begin cyc(); t++; end
        chk("ar_wait", m_axi_arvalid, 1'b1);
        chk("ar_addr", m_axi_araddr, ea);
        repeat (ard) cyc();
        m_arready = 1;
        cyc();
        m_arready = 0;
        for (int k = 1; k <= nb; k++) begin
            m_rdata  = db + 64'(k - 1);
            m_rvalid = 1;
            m_rlast  = (k == nb);
            if (k >= slo && k <= shi) begin
                if (gid == 1) s1_rready = 0; else s0_rready = 0;
                #1;
                chk("stall_rready", m_axi_rready, 1'b0);
                cyc();
                s0_rready = 1;
                s1_rready = 1;
            end
            #1;
            t = 0;
            while (!m_axi_rready && t < 20) begin cyc(); #1; t++; end
            chk("beat_wait", m_axi_rready, 1'b1);
            cyc();
            if (k == rst_after) begin
                m_rdata = db + 64'(k);
                reset = 1;
                cyc();
                chk("rst_busy", busy, 1'b0);
                chk("rst_rready", m_axi_rready, 1'b0);
                chk("rst_arvalid", m_axi_arvalid, 1'b0);
                chk("rst_grant", grant_id, 1'b0);
                chk("rst_araddr", m_axi_araddr, 64'h0);
                chk("rst_s0_rvalid", s0_axi_rvalid, 1'b0);
                chk("rst_err", burst_err, 1'b0);
                reset = 0; m_rvalid = 0; m_rlast = 0;
                return;
            end
        end
        m_rvalid = 0;
        m_rlast  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cyc();
        chk("reset_busy", busy, 1'b0);
        chk("reset_grant", grant_id, 1'b0);
        chk("reset_araddr", m_axi_araddr, 64'h0);
        chk("reset_err", burst_err, 1'b0);
        reset = 0;
        cyc();
        // single request from s0
        s0_araddr = 64'h1000; left0 = 1; s0v = 1;
        serve(8, 64'hA0, 3, 0, -1, 0, 64'h1000, 0);
        chk("single_busy_after", busy, 1'b0);
        chk("single_s1_beats", got1.size(), 0);
        chk("single_s0_beats", got0.size(), 8);
        for (int i = 0; i < got0.size(); i++) chk("single_beat", got0[i], 64'hA0 + 64'(i));
        // simultaneous requests right after reset: s0 wins first
        reset = 1; cyc(); reset = 0;
        glog.delete();
        s0_araddr = 64'h2000; s1_araddr = 64'h3000; left0 = 1; left1 = 1; s0v = 1; s1v = 1;
        serve(8, 64'h10, 0, 0, -1, 0, 64'h2000, 0);
        serve(8, 64'h20, 1, 0, -1, 1, 64'h3000, 0);
        chk("tie_glog_n", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("tie_first", glog[0], 0);
            chk("tie_second", glog[1], 1);
        end
        // round-robin with both requesters continuously valid
        glog.delete();
        s0_araddr = 64'h4000; s1_araddr = 64'h5000; left0 = 2; left1 = 2; s0v = 1; s1v = 1;
        serve(8, 64'h30, 0, 0, -1, 0, 64'h4000, 0);
        serve(8, 64'h40, 0, 0, -1, 1, 64'h5000, 0);
        serve(8, 64'h50, 0, 0, -1, 0, 64'h4000, 0);
        serve(8, 64'h60, 0, 0, -1, 1, 64'h5000, 0);
        chk("rr_glog_n", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("rr_0", glog[0], 0);
            chk("rr_1", glog[1], 1);
            chk("rr_2", glog[2], 0);
            chk("rr_3", glog[3], 1);
        end
        // backpressure on s1 during beats 3..5
        got1.delete();
        s1_araddr = 64'h6000; left1 = 1; s1v = 1;
        serve(8, 64'hB0, 2, 3, 5, 1, 64'h6000, 0);
        chk("bp_beats", got1.size(), 8);
        for (int i = 0; i < got1.size(); i++) chk("bp_beat", got1[i], 64'hB0 + 64'(i));
        chk("bp_err", burst_err, 1'b0);
        // short burst: rlast on beat 6
        s0_araddr = 64'h7000; left0 = 1; s0v = 1;
        serve(6, 64'hC0, 0, 0, -1, 0, 64'h7000, 0);
        chk("short_released", busy, 1'b0);
        chk("short_err", burst_err, CHK);
        repeat (2) cyc();
        chk("short_err_held", burst_err, CHK);
        // reset after beat 4 of a burst
        s0_araddr = 64'h8000; left0 = 1; s0v = 1;
        serve(8, 64'hD0, 1, 0, -1, 0, 64'h8000, 4);
        repeat (2) cyc();
        chk("post_rst_idle", busy, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
